// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-master memory arbiter.
//   - FSM state encodings (IDLE / OWN0 / OWN1) and the matching enum
//   - DEFAULT_TIMEOUT: default grant timeout in cycles
//   - bus_ctl_t: the four single-bit Wishbone-style controls of one master
//   - own_state(): maps a master index onto its ownership state
package mem_arbiter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_OWN0 = OWN0,
    ST_OWN1 = OWN1
  } arb_state_e;

  typedef struct packed {
    logic cyc;
    logic stb;
    logic we;
    logic rd;
  } bus_ctl_t;

  function automatic arb_state_e own_state(input logic m);
    return m ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: per-transaction wait counter for the arbiter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to zero (wins over en)
//   en       : advance count by one
//   tc       : terminal count, high while count == TIMEOUT-1
import mem_arbiter_pkg::*;

module arb_timeout_counter #(
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants a single-port data memory to one of two Wishbone-style
// masters per transaction and releases hung grants after TIMEOUT cycles.
//   ar_clk / ar_rst         : clock, synchronous active-high reset
//   ar_mN_*  (N = 0, 1)     : master N controls, addresses, store data, byte
//                             enables in; ack / stall / err / read data out
//   ar_s_*                  : memory side; strobes, addresses, data out,
//                             read data / ack / stall in
// Build option: MEM_ARBITER_ROUND_ROBIN_EN -- when defined, simultaneous
// requests from IDLE alternate (winner is the master not served last);
// otherwise master 0 always wins a tie.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int AWIDTH  = 5,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              ar_clk,
  input  logic              ar_rst,
  // master 0
  input  logic              ar_m0_cyc,
  input  logic              ar_m0_stb,
  input  logic              ar_m0_we,
  input  logic              ar_m0_rd,
  input  logic [AWIDTH-1:0] ar_m0_load_addr,
  input  logic [AWIDTH-1:0] ar_m0_store_addr,
  input  logic [DWIDTH-1:0] ar_m0_data_store,
  input  logic [3:0]        ar_m0_byte_enable,
  output logic              ar_m0_ack,
  output logic              ar_m0_stall,
  output logic              ar_m0_err,
  output logic [DWIDTH-1:0] ar_m0_read_data,
  // master 1
  input  logic              ar_m1_cyc,
  input  logic              ar_m1_stb,
  input  logic              ar_m1_we,
  input  logic              ar_m1_rd,
  input  logic [AWIDTH-1:0] ar_m1_load_addr,
  input  logic [AWIDTH-1:0] ar_m1_store_addr,
  input  logic [DWIDTH-1:0] ar_m1_data_store,
  input  logic [3:0]        ar_m1_byte_enable,
  output logic              ar_m1_ack,
  output logic              ar_m1_stall,
  output logic              ar_m1_err,
  output logic [DWIDTH-1:0] ar_m1_read_data,
  // memory
  output logic              ar_s_cyc,
  output logic              ar_s_stb,
  output logic              ar_s_we,
  output logic              ar_s_rd,
  output logic [AWIDTH-1:0] ar_s_load_addr,
  output logic [AWIDTH-1:0] ar_s_store_addr,
  output logic [DWIDTH-1:0] ar_s_data_store,
  output logic [3:0]        ar_s_byte_enable,
  input  logic [DWIDTH-1:0] ar_s_read_data,
  input  logic              ar_s_ack,
  input  logic              ar_s_stall
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  bus_ctl_t ctl0, ctl1, own_ctl;
  logic     req0, req1;
  logic     owned, owner;
  logic     tie_pick;
  logic     tmr_clr, tmr_tc;
  logic     timed_out;

  assign ctl0 = {ar_m0_cyc, ar_m0_stb, ar_m0_we, ar_m0_rd};
  assign ctl1 = {ar_m1_cyc, ar_m1_stb, ar_m1_we, ar_m1_rd};
  assign req0 = ctl0.cyc & ctl0.stb;
  assign req1 = ctl1.cyc & ctl1.stb;

  assign owned   = (state_q != ST_IDLE);
  assign owner   = (state_q == ST_OWN1);
  assign own_ctl = owner ? ctl1 : ctl0;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  assign tie_pick = ~last_q;
`else
  assign tie_pick = 1'b0;
`endif

  // Timer runs only while a grant is outstanding; any exit path clears it so
  // the next grant starts counting from zero.
  assign tmr_clr   = ~owned | ar_s_ack | ~own_ctl.cyc | tmr_tc;
  // ack and owner abort both take priority over the timeout
  assign timed_out = owned & ~ar_s_ack & own_ctl.cyc & tmr_tc;

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk (ar_clk),
    .rst (ar_rst),
    .clr (tmr_clr),
    .en  (owned),
    .tc  (tmr_tc)
  );

  always_ff @(posedge ar_clk) begin
    if (ar_rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = own_state(tie_pick);
        else if (req0)    state_d = ST_OWN0;
        else if (req1)    state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (ar_s_ack) begin
          state_d = ST_IDLE;
          last_d  = owner;
        end else if (!own_ctl.cyc) begin
          // aborted transaction does not count as service
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          state_d = ST_IDLE;
          last_d  = owner;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ar_s_cyc         = 1'b0;
    ar_s_stb         = 1'b0;
    ar_s_we          = 1'b0;
    ar_s_rd          = 1'b0;
    ar_s_load_addr   = '0;
    ar_s_store_addr  = '0;
    ar_s_data_store  = '0;
    ar_s_byte_enable = '0;
    ar_m0_ack        = 1'b0;
    ar_m1_ack        = 1'b0;
    ar_m0_err        = 1'b0;
    ar_m1_err        = 1'b0;
    ar_m0_stall      = req0;
    ar_m1_stall      = req1;
    if (owned) begin
      ar_s_cyc         = own_ctl.cyc;
      ar_s_stb         = own_ctl.stb;
      ar_s_we          = own_ctl.we;
      ar_s_rd          = own_ctl.rd;
      ar_s_load_addr   = owner ? ar_m1_load_addr   : ar_m0_load_addr;
      ar_s_store_addr  = owner ? ar_m1_store_addr  : ar_m0_store_addr;
      ar_s_data_store  = owner ? ar_m1_data_store  : ar_m0_data_store;
      ar_s_byte_enable = owner ? ar_m1_byte_enable : ar_m0_byte_enable;
      if (owner) begin
        ar_m1_ack   = ar_s_ack;
        ar_m1_stall = ar_s_stall;
        ar_m1_err   = timed_out;
        ar_m0_stall = ar_m0_cyc;
      end else begin
        ar_m0_ack   = ar_s_ack;
        ar_m0_stall = ar_s_stall;
        ar_m0_err   = timed_out;
        ar_m1_stall = ar_m1_cyc;
      end
    end
  end

  // read data is broadcast; masters qualify it with their own ack
  assign ar_m0_read_data = ar_s_read_data;
  assign ar_m1_read_data = ar_s_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int OW = 4 + 2*AW + DW + 4 + 6 + 2*DW;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic ar_clk, ar_rst;
  logic [1:0]          m_cyc, m_stb, m_we, m_rd;
  logic [1:0][AW-1:0]  m_la, m_sa;
  logic [1:0][DW-1:0]  m_ds;
  logic [1:0][3:0]     m_be;
  logic [1:0]          m_ack, m_stall, m_err;
  logic [1:0][DW-1:0]  m_rdata;
  logic ar_s_cyc, ar_s_stb, ar_s_we, ar_s_rd;
  logic [AW-1:0] ar_s_load_addr, ar_s_store_addr;
  logic [DW-1:0] ar_s_data_store, ar_s_read_data;
  logic [3:0]    ar_s_byte_enable;
  logic ar_s_ack, ar_s_stall;

  int total = 0;
  int bad   = 0;

  // reference model: owner (-1 none), last served master, cycles waited
  int mo = -1;
  int ml = 1;
  int mw = 0;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .ar_clk(ar_clk), .ar_rst(ar_rst),
    .ar_m0_cyc(m_cyc[0]), .ar_m0_stb(m_stb[0]), .ar_m0_we(m_we[0]), .ar_m0_rd(m_rd[0]),
    .ar_m0_load_addr(m_la[0]), .ar_m0_store_addr(m_sa[0]), .ar_m0_data_store(m_ds[0]),
    .ar_m0_byte_enable(m_be[0]), .ar_m0_ack(m_ack[0]), .ar_m0_stall(m_stall[0]),
    .ar_m0_err(m_err[0]), .ar_m0_read_data(m_rdata[0]),
    .ar_m1_cyc(m_cyc[1]), .ar_m1_stb(m_stb[1]), .ar_m1_we(m_we[1]), .ar_m1_rd(m_rd[1]),
    .ar_m1_load_addr(m_la[1]), .ar_m1_store_addr(m_sa[1]), .ar_m1_data_store(m_ds[1]),
    .ar_m1_byte_enable(m_be[1]), .ar_m1_ack(m_ack[1]), .ar_m1_stall(m_stall[1]),
    .ar_m1_err(m_err[1]), .ar_m1_read_data(m_rdata[1]),
    .ar_s_cyc(ar_s_cyc), .ar_s_stb(ar_s_stb), .ar_s_we(ar_s_we), .ar_s_rd(ar_s_rd),
    .ar_s_load_addr(ar_s_load_addr), .ar_s_store_addr(ar_s_store_addr),
    .ar_s_data_store(ar_s_data_store), .ar_s_byte_enable(ar_s_byte_enable),
    .ar_s_read_data(ar_s_read_data), .ar_s_ack(ar_s_ack), .ar_s_stall(ar_s_stall)
  );

  initial begin
    ar_clk = 1'b0;
    forever #5 ar_clk = ~ar_clk;
  end

  function automatic logic [OW-1:0] observed();
    return {ar_s_cyc, ar_s_stb, ar_s_we, ar_s_rd, ar_s_load_addr, ar_s_store_addr,
            ar_s_data_store, ar_s_byte_enable, m_ack, m_stall, m_err, m_rdata};
  endfunction

  // expected outputs for the current cycle, from model state + live inputs
  function automatic logic [OW-1:0] expected();
    logic [3:0] ctl; logic [AW-1:0] la, sa; logic [DW-1:0] ds; logic [3:0] be;
    logic [1:0] ack, stall, err;
    ctl = '0; la = '0; sa = '0; ds = '0; be = '0; ack = '0; err = '0;
    stall = m_cyc & m_stb;
    if (mo >= 0) begin
      ctl = {m_cyc[mo], m_stb[mo], m_we[mo], m_rd[mo]};
      la = m_la[mo]; sa = m_sa[mo]; ds = m_ds[mo]; be = m_be[mo];
      stall = m_cyc;
      stall[mo] = ar_s_stall;
      ack[mo]   = ar_s_ack;
      err[mo]   = !ar_s_ack && m_cyc[mo] && (mw == TO-1);
    end
    return {ctl, la, sa, ds, be, ack, stall, err, ar_s_read_data, ar_s_read_data};
  endfunction

  // advance the model by one clock edge, then the clock itself
  task automatic advance();
    logic r0, r1;
    r0 = m_cyc[0] & m_stb[0];
    r1 = m_cyc[1] & m_stb[1];
    if (ar_rst) begin
      mo = -1; ml = 1; mw = 0;
    end else if (mo < 0) begin
      mw = 0;
      if (r0 && r1) mo = RR ? ((ml == 1) ? 0 : 1) : 0;
      else if (r0) mo = 0;
      else if (r1) mo = 1;
    end else if (ar_s_ack) begin
      ml = mo; mo = -1; mw = 0;
    end else if (!m_cyc[mo]) begin
      mo = -1; mw = 0;
    end else if (mw == TO-1) begin
      ml = mo; mo = -1; mw = 0;
    end else begin
      mw++;
    end
    @(posedge ar_clk);
    #1;
  endtask

  task automatic do_reset();
    m_cyc = '0; m_stb = '0; m_we = '0; m_rd = '0;
    m_la = '0; m_sa = '0; m_ds = '0; m_be = '0;
    ar_s_ack = 1'b0; ar_s_stall = 1'b0; ar_s_read_data = '0;
    ar_rst = 1'b1;
    advance();
    ar_rst = 1'b0;
  endtask

  task automatic test_reset();
    m_cyc = '0; m_stb = '0; m_we = '0; m_rd = '0;
    m_la = '0; m_sa = '0; m_ds = '0; m_be = '0;
    ar_s_ack = 1'b0; ar_s_stall = 1'b0; ar_s_read_data = 32'h1234_5678;
    ar_rst = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_rd[0] = 1'b1; m_la[0] = 5'd7;
    advance();
    for (int i = 0; i < 2; i++) begin
      @(negedge ar_clk);
      total++; if (observed() !== expected()) begin bad++; $display("FAIL reset_bundle got=%h exp=%h", observed(), expected()); end
      total++; if (ar_s_cyc !== 1'b0) begin bad++; $display("FAIL reset_s_cyc got=%b exp=0", ar_s_cyc); end
      total++; if (m_stall[0] !== 1'b1) begin bad++; $display("FAIL reset_m0_stall got=%b exp=1", m_stall[0]); end
      advance();
    end
    ar_rst = 1'b0;
    @(negedge ar_clk);
    total++; if (ar_s_cyc !== 1'b0) begin bad++; $display("FAIL release_idle_s_cyc got=%b exp=0", ar_s_cyc); end
    advance();
    @(negedge ar_clk);
    total++; if ({ar_s_cyc, ar_s_load_addr} !== {1'b1, 5'd7}) begin bad++; $display("FAIL own0_after_reset got=%b/%0d exp=1/7", ar_s_cyc, ar_s_load_addr); end
    total++; if (observed() !== expected()) begin bad++; $display("FAIL own0_bundle got=%h exp=%h", observed(), expected()); end
    advance();
  endtask

  task automatic test_single_load();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_rd[0] = 1'b1; m_la[0] = 5'd5;
    @(negedge ar_clk);
    total++; if ({ar_s_cyc, m_stall[0]} !== 2'b01) begin bad++; $display("FAIL load_idle got=%b exp=01", {ar_s_cyc, m_stall[0]}); end
    advance();
    @(negedge ar_clk);
    total++; if ({ar_s_cyc, ar_s_rd, ar_s_load_addr} !== {2'b11, 5'd5}) begin bad++; $display("FAIL load_strobe got=%b exp=%b", {ar_s_cyc, ar_s_rd, ar_s_load_addr}, {2'b11, 5'd5}); end
    total++; if (observed() !== expected()) begin bad++; $display("FAIL load_bundle got=%h exp=%h", observed(), expected()); end
    advance();
    ar_s_ack = 1'b1; ar_s_read_data = 32'hDEAD_BEEF;
    @(negedge ar_clk);
    total++; if ({m_ack[0], m_ack[1]} !== 2'b10) begin bad++; $display("FAIL load_ack got=%b exp=10", {m_ack[0], m_ack[1]}); end
    total++; if (m_rdata[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_data got=%h exp=deadbeef", m_rdata[0]); end
    advance();
    ar_s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge ar_clk);
    total++; if (ar_s_cyc !== 1'b0) begin bad++; $display("FAIL load_back_idle got=%b exp=0", ar_s_cyc); end
    advance();
  endtask

  task automatic test_tie();
    logic [AW-1:0] exp_addr [6];
    exp_addr = '{5'd0, 5'd1, 5'd0, RR ? 5'd2 : 5'd1, 5'd0, 5'd1};
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; m_rd = 2'b11;
    m_la[0] = 5'd1; m_la[1] = 5'd2;
    ar_s_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ar_clk);
      total++; if (ar_s_load_addr !== exp_addr[c]) begin bad++; $display("FAIL tie_winner c=%0d got=%0d exp=%0d", c, ar_s_load_addr, exp_addr[c]); end
      total++; if (observed() !== expected()) begin bad++; $display("FAIL tie_bundle c=%0d got=%h exp=%h", c, observed(), expected()); end
      advance();
    end
    m_cyc = '0; m_stb = '0; ar_s_ack = 1'b0;
  endtask

  task automatic test_store_m1();
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_sa[1] = 5'd3; m_ds[1] = 32'h0000_00AA; m_be[1] = 4'b0001;
    advance();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_rd[0] = 1'b1; m_la[0] = 5'd9;
    for (int i = 0; i < 4; i++) begin
      ar_s_ack = (i == 3); ar_s_stall = (i < 3);
      @(negedge ar_clk);
      total++; if ({ar_s_we, ar_s_store_addr, ar_s_data_store, ar_s_byte_enable} !== {1'b1, 5'd3, 32'hAA, 4'b0001}) begin
        bad++; $display("FAIL store_slave i=%0d got=%b/%0d/%h/%b", i, ar_s_we, ar_s_store_addr, ar_s_data_store, ar_s_byte_enable); end
      total++; if (m_stall[0] !== 1'b1) begin bad++; $display("FAIL store_m0_stall i=%0d got=%b exp=1", i, m_stall[0]); end
      total++; if (observed() !== expected()) begin bad++; $display("FAIL store_bundle i=%0d got=%h exp=%h", i, observed(), expected()); end
      advance();
    end
    ar_s_ack = 1'b0; ar_s_stall = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge ar_clk);
      total++; if (observed() !== expected()) begin bad++; $display("FAIL store_after i=%0d got=%h exp=%h", i, observed(), expected()); end
      advance();
    end
    m_cyc = '0; m_stb = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_rd[0] = 1'b1; m_la[0] = 5'd4;
    advance();
    for (int k = 1; k <= TO; k++) begin
      @(negedge ar_clk);
      total++; if (m_err[0] !== (k == TO)) begin bad++; $display("FAIL timeout_err k=%0d got=%b exp=%b", k, m_err[0], k == TO); end
      total++; if (observed() !== expected()) begin bad++; $display("FAIL timeout_bundle k=%0d got=%h exp=%h", k, observed(), expected()); end
      advance();
    end
    // master still requesting, yet the grant has been released for one cycle
    @(negedge ar_clk);
    total++; if ({ar_s_cyc, m_err[0]} !== 2'b00) begin bad++; $display("FAIL timeout_release got=%b exp=00", {ar_s_cyc, m_err[0]}); end
    advance();
    m_cyc = '0; m_stb = '0;
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_rd[0] = 1'b1;
    advance();
    for (int k = 1; k <= TO; k++) begin
      ar_s_ack = (k == TO);
      @(negedge ar_clk);
      if (k == TO) begin
        total++; if ({m_ack[0], m_err[0]} !== 2'b10) begin bad++; $display("FAIL ack_vs_timeout got=%b exp=10", {m_ack[0], m_err[0]}); end
      end
      total++; if (observed() !== expected()) begin bad++; $display("FAIL ackto_bundle k=%0d got=%h exp=%h", k, observed(), expected()); end
      advance();
    end
    ar_s_ack = 1'b0; m_cyc = '0; m_stb = '0;
  endtask

  task automatic test_cyc_drop();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_la[0] = 5'd1; ar_s_ack = 1'b1;
    advance();
    advance();                              // master 0 served -> last = 0
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; ar_s_ack = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_la[1] = 5'd2;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin m_cyc[1] = 1'b0; m_stb[1] = 1'b0; end
      if (c == 4) begin m_cyc = 2'b11; m_stb = 2'b11; end
      @(negedge ar_clk);
      total++; if (m_err !== 2'b00) begin bad++; $display("FAIL drop_err c=%0d got=%b exp=00", c, m_err); end
      if (c == 4) begin
        total++; if (ar_s_cyc !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b exp=0", ar_s_cyc); end
      end
      total++; if (observed() !== expected()) begin bad++; $display("FAIL drop_bundle c=%0d got=%h exp=%h", c, observed(), expected()); end
      advance();
    end
    // aborted grant leaves last on master 0, so a tie goes to master 1 under RR
    @(negedge ar_clk);
    total++; if (ar_s_load_addr !== (RR ? 5'd2 : 5'd1)) begin bad++; $display("FAIL drop_last got=%0d exp=%0d", ar_s_load_addr, RR ? 2 : 1); end
    advance();
    m_cyc = '0; m_stb = '0;
  endtask

  task automatic test_random();
    logic [1:0] busy, rel;
    int ackp;
    busy = '0; rel = '0; ackp = 2;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) ackp = ((c / 300) % 2 == 1) ? 40 : 2;
      ar_rst = ($urandom_range(0, 199) == 0);
      ar_s_ack = ($urandom_range(1, ackp) == 1);
      ar_s_stall = 1'($urandom_range(0, 1));
      ar_s_read_data = $urandom;
      for (int n = 0; n < 2; n++) begin
        if (busy[n]) begin
          if (rel[n] || $urandom_range(0, 31) == 0) begin
            busy[n] = 1'b0; m_cyc[n] = 1'b0; m_stb[n] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          busy[n] = 1'b1; m_cyc[n] = 1'b1; m_stb[n] = 1'b1;
          m_we[n] = 1'($urandom_range(0, 1)); m_rd[n] = ~m_we[n];
          m_la[n] = AW'($urandom); m_sa[n] = AW'($urandom);
          m_ds[n] = $urandom; m_be[n] = 4'($urandom);
        end else begin
          m_cyc[n] = ($urandom_range(0, 7) == 0); m_stb[n] = 1'b0;
        end
      end
      @(negedge ar_clk);
      total++; if (observed() !== expected()) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", c, observed(), expected()); end
      for (int n = 0; n < 2; n++)
        rel[n] = (mo == n) && !ar_rst && (ar_s_ack || (m_cyc[n] && mw == TO-1));
      advance();
    end
    ar_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_tie();
    test_store_m1();
    test_timeout();
    test_ack_at_timeout();
    test_cyc_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
